// File: rtl/ip_codma_mem_arbiter_if.sv
// Bundle of the read-engine, write-engine and memory-port signals around the codma arbiter.
// slave: the arbiter's view. master: the surrounding engines and memory.
interface ip_codma_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_gnt_o;
    logic          rd_ack_o;
    logic [DW-1:0] rd_data_o;
    logic          wr_req_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          wr_gnt_o;
    logic          wr_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i;
    logic [DW-1:0] mem_rdata_i;

    modport slave (
        input  rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, mem_ack_i, mem_rdata_i,
        output rd_gnt_o, rd_ack_o, rd_data_o, wr_gnt_o, wr_ack_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output rd_req_i, rd_addr_i, wr_req_i, wr_addr_i, wr_data_i, mem_ack_i, mem_rdata_i,
        input  rd_gnt_o, rd_ack_o, rd_data_o, wr_gnt_o, wr_ack_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/ip_codma_mem_arbiter.sv
// Round-robin arbiter with burst lock and beat-count pre-emption sharing the codma memory port
// between the DMA read and write engines.
//
// state    | meaning
// ARB_IDLE | port unowned, no memory beats issued
// ARB_RD   | read engine owns the port
// ARB_WR   | write engine owns the port
module ip_codma_mem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    ip_codma_mem_arbiter_if.slave   bus,
    input  logic                    abort_i,
    output logic                    busy_o
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

    localparam logic [1:0] ARB_IDLE = 2'b00;
    localparam logic [1:0] ARB_RD   = 2'b01;
    localparam logic [1:0] ARB_WR   = 2'b10;

    localparam logic LG_RD = 1'b0;
    localparam logic LG_WR = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;

    logic          own_rd, own_wr, own_req, oth_req;
    logic          mem_req, beat_ack;
    logic [CW-1:0] beat_inc;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux, rdata_mux;

    always_comb begin
        own_rd    = (state_q == ARB_RD);
        own_wr    = (state_q == ARB_WR);
        own_req   = (own_rd & bus.rd_req_i) | (own_wr & bus.wr_req_i);
        oth_req   = (own_rd & bus.wr_req_i) | (own_wr & bus.rd_req_i);
        mem_req   = own_req & ~abort_i;
        beat_ack  = mem_req & bus.mem_ack_i;
        beat_inc  = beat_cnt_q + 1'b1;
        addr_mux  = own_rd ? bus.rd_addr_i : (own_wr ? bus.wr_addr_i : '0);
        wdata_mux = own_wr ? bus.wr_data_i : '0;
        rdata_mux = (beat_ack & own_rd) ? bus.mem_rdata_i : '0;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (abort_i) begin
                    beat_cnt_d = '0;
                end else if (bus.rd_req_i && (!bus.wr_req_i || last_grant_q == LG_WR)) begin
                    state_d      = ARB_RD;
                    last_grant_d = LG_RD;
                    beat_cnt_d   = '0;
                end else if (bus.wr_req_i) begin
                    state_d      = ARB_WR;
                    last_grant_d = LG_WR;
                    beat_cnt_d   = '0;
                end
            end
            ARB_RD, ARB_WR: begin
                if (abort_i) begin
                    state_d    = ARB_IDLE;
                    beat_cnt_d = '0;
                end else if (!own_req) begin
                    beat_cnt_d = '0;
                    if (oth_req) begin
                        state_d      = own_rd ? ARB_WR : ARB_RD;
                        last_grant_d = own_rd ? LG_WR : LG_RD;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (beat_ack) begin
                    if (beat_inc == MAX_CNT) begin
                        // burst quota used up: hand over if the other engine waits, else restart the count
                        beat_cnt_d = '0;
                        if (oth_req) begin
                            state_d      = own_rd ? ARB_WR : ARB_RD;
                            last_grant_d = own_rd ? LG_WR : LG_RD;
                        end
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end
            default: begin
                state_d    = ARB_IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= LG_WR;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign bus.rd_gnt_o    = own_rd;
    assign bus.wr_gnt_o    = own_wr;
    assign bus.rd_ack_o    = beat_ack & own_rd;
    assign bus.wr_ack_o    = beat_ack & own_wr;
    assign bus.rd_data_o   = rdata_mux;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = own_wr;
    assign bus.mem_addr_o  = addr_mux;
    assign bus.mem_wdata_o = wdata_mux;
    assign busy_o          = (state_q != ARB_IDLE);
endmodule

// File: tb/tb_ip_codma_mem_arbiter.sv
// Directed scenarios plus randomized engine/memory traffic for ip_codma_mem_arbiter,
// checked cycle by cycle against an ownership/quota reference model.
module tb_ip_codma_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXB = 8;

    logic clk_i = 1'b0;
    logic reset_i;
    logic abort_i;
    logic busy_o;

    ip_codma_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ip_codma_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BEATS(MAXB)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus),
        .abort_i (abort_i),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 read, 2 write), who was last granted, beats served.
    int owner, last_owner, served;
    logic e_rd_ack, e_wr_ack;

    task automatic model_reset();
        owner = 0; last_owner = 2; served = 0;
        e_rd_ack = 1'b0; e_wr_ack = 1'b0;
    endtask

    function automatic logic req_of(input int ch);
        return (ch == 1) ? bus.rd_req_i : (ch == 2) ? bus.wr_req_i : 1'b0;
    endfunction

    task automatic model_check();
        logic beat_live, acked;
        logic [31:0] e_addr;
        beat_live = req_of(owner) && !abort_i;
        acked     = beat_live && bus.mem_ack_i;
        e_rd_ack  = acked && owner == 1;
        e_wr_ack  = acked && owner == 2;
        e_addr    = (owner == 1) ? bus.rd_addr_i : (owner == 2) ? bus.wr_addr_i : 32'h0;
        check_eq("rd_gnt",    32'(bus.rd_gnt_o),  32'(owner == 1));
        check_eq("wr_gnt",    32'(bus.wr_gnt_o),  32'(owner == 2));
        check_eq("busy",      32'(busy_o),        32'(owner != 0));
        check_eq("mem_req",   32'(bus.mem_req_o), 32'(beat_live));
        check_eq("mem_we",    32'(bus.mem_we_o),  32'(owner == 2));
        check_eq("mem_addr",  bus.mem_addr_o,     e_addr);
        check_eq("mem_wdata", bus.mem_wdata_o,    (owner == 2) ? bus.wr_data_i : 32'h0);
        check_eq("rd_ack",    32'(bus.rd_ack_o),  32'(e_rd_ack));
        check_eq("wr_ack",    32'(bus.wr_ack_o),  32'(e_wr_ack));
        check_eq("rd_data",   bus.rd_data_o,      e_rd_ack ? bus.mem_rdata_i : 32'h0);
    endtask

    task automatic give_port(input int ch);
        owner = ch; last_owner = ch; served = 0;
    endtask

    task automatic model_update();
        int other;
        if (abort_i) begin
            owner = 0; served = 0;
        end else if (owner == 0) begin
            if (bus.rd_req_i && bus.wr_req_i) give_port(3 - last_owner);
            else if (bus.rd_req_i) give_port(1);
            else if (bus.wr_req_i) give_port(2);
        end else begin
            other = 3 - owner;
            if (!req_of(owner)) begin
                if (req_of(other)) give_port(other);
                else begin owner = 0; served = 0; end
            end else if (e_rd_ack || e_wr_ack) begin
                served++;
                if (served == MAXB) begin
                    if (req_of(other)) give_port(other);
                    else served = 0;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic step();
        #2;
        model_check();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.rd_req_i = 0; bus.rd_addr_i = '0;
        bus.wr_req_i = 0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        abort_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    int rd_left, wr_left;

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_eq("rst_gnts",  32'({bus.rd_gnt_o, bus.wr_gnt_o}), 32'h0);
        check_eq("rst_mem",   32'({bus.mem_req_o, bus.mem_we_o}), 32'h0);
        check_eq("rst_busy",  32'(busy_o), 32'h0);
        check_eq("rst_addr",  bus.mem_addr_o, 32'h0);
        reset_i = 1'b0;

        // single read beat
        bus.rd_req_i = 1; bus.rd_addr_i = 32'h0000_1000;
        step();
        check_eq("s1_rd_gnt", 32'(bus.rd_gnt_o), 32'h1);
        check_eq("s1_addr",   bus.mem_addr_o, 32'h0000_1000);
        check_eq("s1_we",     32'(bus.mem_we_o), 32'h0);
        bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hA5A5_0001;
        #1;
        check_eq("s1_rd_ack",  32'(bus.rd_ack_o), 32'h1);
        check_eq("s1_rd_data", bus.rd_data_o, 32'hA5A5_0001);
        step();
        bus.rd_req_i = 0; bus.mem_ack_i = 0;
        step(); step();

        // tie after reset goes to read; read releases after 2 beats, write follows without a gap
        do_reset();
        bus.rd_req_i = 1; bus.wr_req_i = 1; bus.rd_addr_i = 32'h20; bus.wr_addr_i = 32'h40;
        bus.wr_data_i = 32'hDEAD_0002;
        step();
        check_eq("s2_tie_rd", 32'({bus.rd_gnt_o, bus.wr_gnt_o}), 32'h2);
        bus.mem_ack_i = 1;
        step(); step();
        bus.rd_req_i = 0; bus.mem_ack_i = 0;
        step();
        check_eq("s2_wr_gnt", 32'({bus.rd_gnt_o, bus.wr_gnt_o}), 32'h1);
        check_eq("s2_we",     32'(bus.mem_we_o), 32'h1);
        bus.wr_req_i = 0;
        step(); step();

        // both busy: blocks of MAXB beats alternate
        do_reset();
        bus.rd_req_i = 1; bus.wr_req_i = 1; bus.mem_ack_i = 1;
        step();
        for (int i = 0; i < 2 * MAXB; i++) begin
            bus.rd_addr_i = $urandom; bus.wr_addr_i = $urandom; bus.wr_data_i = $urandom;
            bus.mem_rdata_i = $urandom;
            #1;
            check_eq("s3_rd_ack", 32'(bus.rd_ack_o), 32'(i < MAXB));
            check_eq("s3_wr_ack", 32'(bus.wr_ack_o), 32'(i >= MAXB));
            step();
        end
        check_eq("s3_back_rd", 32'(bus.rd_gnt_o), 32'h1);

        // write alone keeps the port across quota boundaries
        do_reset();
        bus.wr_req_i = 1; bus.mem_ack_i = 1;
        step();
        for (int i = 0; i < 20; i++) begin
            bus.wr_addr_i = $urandom; bus.wr_data_i = $urandom;
            #1;
            check_eq("s4_wr_gnt", 32'(bus.wr_gnt_o), 32'h1);
            check_eq("s4_wr_ack", 32'(bus.wr_ack_o), 32'h1);
            step();
        end

        // abort during a pending read beat
        do_reset();
        bus.rd_req_i = 1;
        step();
        bus.mem_ack_i = 1; abort_i = 1;
        #1;
        check_eq("s5_mem_req", 32'(bus.mem_req_o), 32'h0);
        check_eq("s5_rd_ack",  32'(bus.rd_ack_o), 32'h0);
        step();
        abort_i = 0; bus.mem_ack_i = 0; bus.rd_req_i = 0;
        check_eq("s5_busy", 32'(busy_o), 32'h0);
        check_eq("s5_gnts", 32'({bus.rd_gnt_o, bus.wr_gnt_o}), 32'h0);
        step();

        // asynchronous reset mid-write, then a tie goes to read
        do_reset();
        bus.wr_req_i = 1;
        step();
        bus.mem_ack_i = 1;
        step();
        #2;
        reset_i = 1'b1;
        clear_inputs();
        #1;
        check_eq("s6_gnts", 32'({bus.rd_gnt_o, bus.wr_gnt_o}), 32'h0);
        check_eq("s6_busy", 32'(busy_o), 32'h0);
        check_eq("s6_mem",  32'({bus.mem_req_o, bus.mem_we_o}), 32'h0);
        model_reset();
        #1;
        reset_i = 1'b0;
        @(posedge clk_i);
        model_update();
        #1;
        bus.rd_req_i = 1; bus.wr_req_i = 1;
        step();
        check_eq("s6_tie_rd", 32'({bus.rd_gnt_o, bus.wr_gnt_o}), 32'h2);

        // randomized engines obeying the hold-until-ack handshake
        do_reset();
        rd_left = 0; wr_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (bus.rd_req_i) begin
                if (e_rd_ack) begin
                    rd_left--;
                    bus.rd_addr_i = $urandom;
                    if (rd_left == 0) bus.rd_req_i = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.rd_req_i = 1; rd_left = $urandom_range(1, 12); bus.rd_addr_i = $urandom;
            end
            if (bus.wr_req_i) begin
                if (e_wr_ack) begin
                    wr_left--;
                    bus.wr_addr_i = $urandom; bus.wr_data_i = $urandom;
                    if (wr_left == 0) bus.wr_req_i = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.wr_req_i = 1; wr_left = $urandom_range(1, 12);
                bus.wr_addr_i = $urandom; bus.wr_data_i = $urandom;
            end
            bus.mem_ack_i   = ($urandom_range(0, 9) < 6);
            bus.mem_rdata_i = $urandom;
            abort_i         = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ip_codma_mem_arbiter.md
Name: ip_codma_mem_arbiter

Overview:
- Shares the single codma memory port between the DMA read engine and the DMA write engine.
- Round-robin arbitration with burst lock: a granted engine keeps the port until it drops its request.
- An engine is pre-empted after MAX_BEATS acknowledged beats if the other engine is waiting.
- Sits between the rd/wr engine state machines and the memory bus; the DMA top-level controller drives abort_i on entry to DMA_ERROR.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_BEATS, 8, acked beats before forced re-arbitration (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
rd_req_i  in  1  read engine request; held high for the whole burst
rd_addr_i  in  AW  read address
rd_gnt_o  out  1  read engine owns the port
rd_ack_o  out  1  read beat complete
rd_data_o  out  DW  read data, valid with rd_ack_o
wr_req_i  in  1  write engine request
wr_addr_i  in  AW  write address
wr_data_i  in  DW  write data
wr_gnt_o  out  1  write engine owns the port
wr_ack_o  out  1  write beat complete
mem_req_o  out  1  memory beat request
mem_we_o  out  1  1 = write beat
mem_addr_o  out  AW  memory address
mem_wdata_o  out  DW  memory write data
mem_ack_i  in  1  memory beat done; rdata valid same cycle
mem_rdata_i  in  DW  memory read data
abort_i  in  1  synchronous abort from DMA controller
busy_o  out  1  state != ARB_IDLE

Behaviour:
- Clocking and reset: one clock, clk_i. reset_i is asynchronous and active-high.
- Reset values: state ARB_IDLE, last_grant_r = WR (read wins the first tie), beat_cnt_r = 0. All outputs 0.
- State encoding (2 bits):
  - ARB_IDLE = 00, ARB_RD = 01, ARB_WR = 10.
  - Code 11 is illegal and transitions to ARB_IDLE.
- ARB_IDLE:
  - Only rd_req_i high -> ARB_RD. Only wr_req_i high -> ARB_WR.
  - Both high -> the channel that is not last_grant_r.
  - Grant appears the cycle after the request is sampled (1-cycle latency). No mem_req_o in IDLE.
- ARB_RD (ARB_WR is symmetric):
  - rd_gnt_o = 1.
  - mem_req_o = rd_req_i & !abort_i. mem_we_o = 0. mem_addr_o = rd_addr_i. Memory mux is combinational from the owning channel.
  - mem_wdata_o = wr_data_i only in ARB_WR, else 0. mem_addr_o = 0 and mem_we_o = 0 in IDLE.
  - rd_ack_o = mem_ack_i & mem_req_o, same cycle. rd_data_o = mem_rdata_i when rd_ack_o is high, else 0.
  - On entry, last_grant_r <= RD and beat_cnt_r <= 0.
- Handshake rule: a requester holds req, addr and wdata stable until its ack. A requester may drop req only in the cycle after an ack, or before its first beat.
- beat_cnt_r: width $clog2(MAX_BEATS+1). Increments on each owner ack.
- Transitions out of an owned state, in priority order:
  1. abort_i -> ARB_IDLE.
  2. Owner req low -> other channel if it is requesting, else ARB_IDLE.
  3. Ack that makes beat_cnt == MAX_BEATS with the other channel requesting -> switch to the other channel. The pre-empted engine keeps req high and waits for re-grant.
  4. Ack that makes beat_cnt == MAX_BEATS with the other channel idle -> stay in the state, beat_cnt_r <= 0 (no wrap past MAX_BEATS).
- Channel switches are edge to edge with no dead cycle. The old grant drops and the new grant rises at the same edge. A switch never occurs while a beat is outstanding.
- abort_i:
  - Gates mem_req_o low in the same cycle.
  - Next state ARB_IDLE, beat_cnt_r <= 0. last_grant_r is unchanged.
  - Overrides all other transitions.
- mem_ack_i while mem_req_o = 0 is ignored: no engine ack, no count.
- reset_i mid-burst: everything returns to reset values immediately (asynchronously). Any in-flight beat is lost; the engines restart.
- Grants are one-hot or zero at all times.

Test Plan:
- Reset, then rd_req_i = 1 alone -> rd_gnt_o = 1 one cycle later. mem_addr_o = rd_addr_i, mem_we_o = 0. mem_ack_i with mem_rdata_i = 0xA5A5_0001 -> rd_ack_o = 1 and rd_data_o = 0xA5A5_0001 in the same cycle.
- rd_req_i and wr_req_i rise together after reset -> read granted first. Read drops req after 2 beats -> wr_gnt_o rises the next edge with no idle cycle, mem_we_o = 1.
- Both requesting, MAX_BEATS = 8 -> on the 8th read ack, grant moves to write. After 8 write beats, grant returns to read. Check 16 beats alternating in blocks of 8.
- Write alone for 20 beats (MAX_BEATS = 8) -> wr_gnt_o stays high throughout. beat_cnt wraps 8 -> 0 with no drop in grant.
- abort_i asserted during a pending read beat -> mem_req_o = 0 that cycle, rd_ack_o = 0 even if mem_ack_i = 1. busy_o = 0 and gnts = 0 next cycle.
- reset_i pulsed asynchronously mid-write -> all outputs 0 immediately. After release, a tie is granted to read.
